// File: rtl/sort7_ctrl.sv
// Sequencing controller for a 7-input combinational sorter: loads seven bytes, captures the
// sorted result and drains it as a byte stream. Define SORT7_ASC_EN for ascending drain order.
module sort7_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic [W-1:0] E,
  output logic [W-1:0] F,
  output logic [W-1:0] G,
  input  logic [W-1:0] Y6,
  input  logic [W-1:0] Y5,
  input  logic [W-1:0] Y4,
  input  logic [W-1:0] Y3,
  input  logic [W-1:0] Y2,
  input  logic [W-1:0] Y1,
  input  logic [W-1:0] Y0,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_t;

  state_t       state;
  logic [2:0]   load_idx;
  logic [2:0]   out_idx;
  logic [W-1:0] ops [7];
  logic [W-1:0] res [7];
  logic [W-1:0] ys  [7];

  assign A = ops[0];
  assign B = ops[1];
  assign C = ops[2];
  assign D = ops[3];
  assign E = ops[4];
  assign F = ops[5];
  assign G = ops[6];

  assign ys[0] = Y0;
  assign ys[1] = Y1;
  assign ys[2] = Y2;
  assign ys[3] = Y3;
  assign ys[4] = Y4;
  assign ys[5] = Y5;
  assign ys[6] = Y6;

  // Maps drain position to result slot; res[k] holds Yk.
  function automatic logic [2:0] slot(input logic [2:0] idx);
`ifdef SORT7_ASC_EN
    return idx;
`else
    return 3'd6 - idx;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StLoad;
      load_idx  <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < 7; i++) begin
        ops[i] <= '0;
        res[i] <= '0;
      end
    end else if (abort) begin
      state     <= StLoad;
      load_idx  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        StLoad: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            ops[load_idx] <= in_data;
            if (load_idx == 3'd6) begin
              load_idx <= '0;
              state    <= StSort;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              load_idx <= load_idx + 3'd1;
            end
          end
        end
        StSort: begin
          for (int i = 0; i < 7; i++) res[i] <= ys[i];
          out_data  <= ys[slot(3'd0)];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          out_idx   <= '0;
          state     <= StDrain;
        end
        StDrain: begin
          if (out_valid && out_ready) begin
            if (out_idx == 3'd6) begin
              state     <= StLoad;
              out_idx   <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              out_idx  <= out_idx + 3'd1;
              out_data <= res[slot(out_idx + 3'd1)];
              out_last <= (out_idx == 3'd5);
            end
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_sort7_ctrl.sv
// Bench for sort7_ctrl: a behavioural sorter drives Y6..Y0, and expected output streams come
// from a queue-sorted copy of each frame.
module tb_sort7_ctrl;

  typedef logic [7:0] frame_t [7];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic [7:0] A, B, C, D, E, F, G;
  logic [7:0] Y6, Y5, Y4, Y3, Y2, Y1, Y0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic [15:0] frame_cnt;

  int ntests = 0;
  int nfail  = 0;
  int exp_cnt = 0;
  logic [7:0] exp_ops [7];

  always #5 clk = ~clk;

  sort7_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .Y6(Y6), .Y5(Y5), .Y4(Y4), .Y3(Y3), .Y2(Y2), .Y1(Y1), .Y0(Y0),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // Stand-in for the combinational sorter: Y0 = minimum, Y6 = maximum.
  logic [7:0] sv [7];
  always_comb begin
    logic [7:0] t;
    sv[0] = A; sv[1] = B; sv[2] = C; sv[3] = D; sv[4] = E; sv[5] = F; sv[6] = G;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 6; j++)
        if (sv[j] > sv[j+1]) begin
          t = sv[j]; sv[j] = sv[j+1]; sv[j+1] = t;
        end
  end
  assign Y0 = sv[0]; assign Y1 = sv[1]; assign Y2 = sv[2]; assign Y3 = sv[3];
  assign Y4 = sv[4]; assign Y5 = sv[5]; assign Y6 = sv[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t expected_order(input frame_t b);
    logic [7:0] q [$];
    frame_t e;
    q = {};
    foreach (b[i]) q.push_back(b[i]);
`ifdef SORT7_ASC_EN
    q.sort();
`else
    q.rsort();
`endif
    foreach (e[i]) e[i] = q[i];
    return e;
  endfunction

  task automatic load_bytes(input frame_t b, input int n, input int bubble_pct);
    int i = 0;
    int guard = 0;
    logic hs;
    while (i < n && guard < 300) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      in_data  = in_valid ? b[i] : 8'($urandom);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        exp_ops[i] = b[i];
        i++;
      end
      guard++;
    end
    in_valid = 1'b0;
    chk("load_done", i, n);
  endtask

  task automatic check_ops(input string tag);
    chk({tag, "_A"}, A, exp_ops[0]); chk({tag, "_B"}, B, exp_ops[1]);
    chk({tag, "_C"}, C, exp_ops[2]); chk({tag, "_D"}, D, exp_ops[3]);
    chk({tag, "_E"}, E, exp_ops[4]); chk({tag, "_F"}, F, exp_ops[5]);
    chk({tag, "_G"}, G, exp_ops[6]);
  endtask

  // mode 0: ready always, 1: toggle starting with a stall, 2: random
  task automatic drain_frame(input frame_t e, input int mode, input int abort_at);
    int k = 0;
    int guard = 0;
    logic rdy, hs, ab;
    while (k < 7 && guard < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = guard[0];
        default: rdy = 1'($urandom_range(1));
      endcase
      out_ready = rdy;
      ab = (abort_at == k) && rdy;
      abort = ab;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, e[k]);
      chk("drain_last", out_last, (k == 6));
      chk("drain_in_ready", in_ready, 0);
      hs = out_valid && rdy;
      @(posedge clk); #1;
      guard++;
      if (ab) begin
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_cnt", frame_cnt, exp_cnt);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        return;
      end
      if (hs) k++;
    end
    out_ready = 1'b0;
    chk("drain_done", k, 7);
    exp_cnt++;
    chk("end_valid", out_valid, 0);
    chk("end_last", out_last, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_busy", busy, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic run_frame(input frame_t b, input int bubble_pct, input int mode,
                           input int abort_at);
    load_bytes(b, 7, bubble_pct);
    check_ops("ops");
    chk("sort_valid", out_valid, 0);
    chk("sort_busy", busy, 1);
    chk("sort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    drain_frame(expected_order(b), mode, abort_at);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    foreach (f[i]) f[i] = 8'($urandom_range(255));
    return f;
  endfunction

  initial begin
    frame_t f1, f80, f17, fp;
    f1  = '{8'd5, 8'd200, 8'd17, 8'd17, 8'd0, 8'd255, 8'd99};
    f80 = '{default: 8'h80};
    f17 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    fp  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd0, 8'd0, 8'd0};
    foreach (exp_ops[i]) exp_ops[i] = 8'd0;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    check_ops("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);

    run_frame(f1, 0, 0, -1);            // basic frame
    run_frame(f1, 0, 1, -1);            // backpressure
    run_frame(rand_frame(), 30, 2, -1); // bubbles, random ready
    run_frame(f80, 40, 0, -1);          // all-equal frame back-to-back

    // Abort after four bytes; the byte offered in the abort cycle must be dropped.
    load_bytes(fp, 4, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_load_in_ready", in_ready, 1);
    chk("abort_load_cnt", frame_cnt, exp_cnt);
    check_ops("abort_keep");
    run_frame(f17, 0, 0, -1);

    // Abort at the third drain handshake, then a normal frame.
    run_frame(rand_frame(), 0, 0, 2);
    run_frame(rand_frame(), 20, 2, -1);
    for (int n = 0; n < 3; n++) run_frame(rand_frame(), 25, 2, -1);

    // Reset in the middle of DRAIN.
    load_bytes(f1, 7, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 0;
    foreach (exp_ops[i]) exp_ops[i] = 8'd0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    check_ops("mid_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    run_frame(f1, 10, 1, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
